// File: rtl/router_pkg.sv
// Shared router constants: packet-controller state codes and FIFO addresses.
// Used by the packet controller, synchronizer and input register block.
package router_pkg;

  localparam logic [2:0] ST_DECODE_ADDRESS     = 3'd0;
  localparam logic [2:0] ST_LOAD_FIRST_DATA    = 3'd1;
  localparam logic [2:0] ST_LOAD_DATA          = 3'd2;
  localparam logic [2:0] ST_FIFO_FULL_STATE    = 3'd3;
  localparam logic [2:0] ST_LOAD_AFTER_FULL    = 3'd4;
  localparam logic [2:0] ST_LOAD_PARITY        = 3'd5;
  localparam logic [2:0] ST_CHECK_PARITY_ERROR = 3'd6;
  localparam logic [2:0] ST_WAIT_TILL_EMPTY    = 3'd7;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = ST_DECODE_ADDRESS,
    LOAD_FIRST_DATA    = ST_LOAD_FIRST_DATA,
    LOAD_DATA          = ST_LOAD_DATA,
    FIFO_FULL_STATE    = ST_FIFO_FULL_STATE,
    LOAD_AFTER_FULL    = ST_LOAD_AFTER_FULL,
    LOAD_PARITY        = ST_LOAD_PARITY,
    CHECK_PARITY_ERROR = ST_CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY    = ST_WAIT_TILL_EMPTY
  } pkt_state_t;

  localparam logic [1:0] ADDR_FIFO0   = 2'd0;
  localparam logic [1:0] ADDR_FIFO1   = 2'd1;
  localparam logic [1:0] ADDR_FIFO2   = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_pkt_ctrl.sv
// Router input-side packet sequencer: header decode, load phases, stalls.
// Optional stall counter enabled by ROUTER_PKT_CTRL_STALL_CNT_EN.
module router_pkt_ctrl
  import router_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
`ifdef ROUTER_PKT_CTRL_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  pkt_state_t state_q;
  pkt_state_t state_d;
  logic [1:0] addr_q;
  logic       sel_empty;
  logic       sel_sr;
  logic       hdr_empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q <= ADDR_FIFO0;
    end else if (state_q == DECODE_ADDRESS && pkt_valid) begin
      addr_q <= data_in;
    end
  end

  always_comb begin
    sel_empty = 1'b0;
    sel_sr    = 1'b0;
    case (addr_q)
      ADDR_FIFO0: begin
        sel_empty = fifo_empty_0;
        sel_sr    = soft_reset_0;
      end
      ADDR_FIFO1: begin
        sel_empty = fifo_empty_1;
        sel_sr    = soft_reset_1;
      end
      ADDR_FIFO2: begin
        sel_empty = fifo_empty_2;
        sel_sr    = soft_reset_2;
      end
      default: begin
        sel_empty = 1'b0;
        sel_sr    = 1'b0;
      end
    endcase
  end

  // Header cycle decides on the incoming address, not the latched one.
  always_comb begin
    hdr_empty = 1'b0;
    case (data_in)
      ADDR_FIFO0: hdr_empty = fifo_empty_0;
      ADDR_FIFO1: hdr_empty = fifo_empty_1;
      ADDR_FIFO2: hdr_empty = fifo_empty_2;
      default:    hdr_empty = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && data_in != ADDR_INVALID) begin
          state_d = hdr_empty ? LOAD_FIRST_DATA
                              : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full) begin
          state_d = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          state_d = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) begin
          state_d = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          state_d = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          state_d = LOAD_PARITY;
        end else begin
          state_d = LOAD_DATA;
        end
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = fifo_full ? FIFO_FULL_STATE
                            : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (sel_empty) begin
          state_d = LOAD_FIRST_DATA;
        end
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // Destination timeout aborts the packet from any active state.
    if (state_q != DECODE_ADDRESS && sel_sr) begin
      state_d = DECODE_ADDRESS;
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b1;
    unique case (1'b1)
      state_q == DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      state_q == LOAD_FIRST_DATA: lfd_state = 1'b1;
      state_q == LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      state_q == FIFO_FULL_STATE: full_state = 1'b1;
      state_q == LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      state_q == LOAD_PARITY: write_enb_reg = 1'b1;
      state_q == CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
      state_q == WAIT_TILL_EMPTY: busy = 1'b1;
      default: busy = 1'b1;
    endcase
  end

`ifdef ROUTER_PKT_CTRL_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] cnt_q;
  logic                   stalling;

  assign stalling = (state_q == FIFO_FULL_STATE) ||
                    (state_q == WAIT_TILL_EMPTY);

  // Saturating; survives soft resets so it spans whole sessions.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (stalling && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Bench for router_pkt_ctrl: directed vector table plus random run
// against a behavioural model of the packet-sequencing rules.
module tb_router_pkt_ctrl;

  localparam int CW = 16;

  // Output vector order: detect,lfd,ld,laf,full,we,rst_int,busy
  localparam logic [7:0] O_DEC = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0100;
  localparam logic [7:0] O_LAF = 8'b0001_0101;
  localparam logic [7:0] O_FUL = 8'b0000_1001;
  localparam logic [7:0] O_LP  = 8'b0000_0101;
  localparam logic [7:0] O_CPE = 8'b0000_0011;
  localparam logic [7:0] O_WTE = 8'b0000_0001;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = 2'd0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty_0 = 1'b1;
  logic       fifo_empty_1 = 1'b1;
  logic       fifo_empty_2 = 1'b1;
  logic       soft_reset_0 = 1'b0;
  logic       soft_reset_1 = 1'b0;
  logic       soft_reset_2 = 1'b0;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;
  logic       busy;
`ifdef ROUTER_PKT_CTRL_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  router_pkt_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk(clk),
    .resetn(resetn),
    .pkt_valid(pkt_valid),
    .data_in(data_in),
    .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0),
    .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0),
    .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2),
    .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add),
    .lfd_state(lfd_state),
    .ld_state(ld_state),
    .laf_state(laf_state),
    .full_state(full_state),
    .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg),
    .busy(busy)
`ifdef ROUTER_PKT_CTRL_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] emp;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    logic [7:0] exp;
    int         cnt;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] outs();
    return {detect_add, lfd_state, ld_state, laf_state,
            full_state, write_enb_reg, rst_int_reg, busy};
  endfunction

  task automatic add(input logic rstn, input logic pv,
                     input logic [1:0] din, input logic full,
                     input logic [2:0] emp, input logic [2:0] sr,
                     input logic pd, input logic lpv,
                     input logic [7:0] exp, input int cnt);
    vec_t v;
    v.rstn = rstn; v.pv = pv; v.din = din; v.full = full;
    v.emp = emp; v.sr = sr; v.pd = pd; v.lpv = lpv;
    v.exp = exp; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rstn, input logic pv,
                       input logic [1:0] din, input logic full,
                       input logic [2:0] emp, input logic [2:0] sr,
                       input logic pd, input logic lpv);
    resetn = rstn; pkt_valid = pv; data_in = din;
    fifo_full = full;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = emp;
    {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
    parity_done = pd; low_pkt_valid = lpv;
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d got %h want %h", name, idx, act, exp);
    end
  endtask

  // Behavioural model: phases by name, rules straight from the spec
  typedef enum int {
    M_DEC, M_LFD, M_LD, M_FUL, M_LAF, M_LP, M_CPE, M_WTE
  } mph_t;

  mph_t m_ph;
  int   m_addr;
  int   m_cnt;

  function automatic logic [7:0] m_outs(input mph_t p);
    logic [7:0] o;
    o[7] = (p == M_DEC);
    o[6] = (p == M_LFD);
    o[5] = (p == M_LD);
    o[4] = (p == M_LAF);
    o[3] = (p == M_FUL);
    o[2] = (p == M_LD) || (p == M_LP) || (p == M_LAF);
    o[1] = (p == M_CPE);
    o[0] = !((p == M_DEC) || (p == M_LD));
    return o;
  endfunction

  task automatic m_step(input logic rstn, input logic pv,
                        input logic [1:0] din, input logic full,
                        input logic [2:0] emp, input logic [2:0] sr,
                        input logic pd, input logic lpv);
    mph_t nx;
    if (!rstn) begin
      m_ph = M_DEC; m_addr = 0; m_cnt = 0;
      return;
    end
    nx = m_ph;
    if (m_ph == M_DEC) begin
      if (pv && din != 2'd3) nx = emp[din] ? M_LFD : M_WTE;
    end else if (m_ph == M_LFD) nx = M_LD;
    else if (m_ph == M_LD) begin
      if (full) nx = M_FUL;
      else if (!pv) nx = M_LP;
    end else if (m_ph == M_FUL) begin
      if (!full) nx = M_LAF;
    end else if (m_ph == M_LAF) begin
      nx = pd ? M_DEC : (lpv ? M_LP : M_LD);
    end else if (m_ph == M_LP) nx = M_CPE;
    else if (m_ph == M_CPE) nx = full ? M_FUL : M_DEC;
    else if (m_ph == M_WTE) begin
      if (emp[m_addr]) nx = M_LFD;
    end
    if (m_ph != M_DEC && m_addr < 3 && sr[m_addr]) nx = M_DEC;
    if ((m_ph == M_FUL || m_ph == M_WTE) && m_cnt < (1 << CW) - 1)
      m_cnt++;
    if (m_ph == M_DEC && pv) m_addr = int'(din);
    m_ph = nx;
  endtask

  initial begin
    // rstn pv din full emp sr pd lpv exp cnt
    add(0,0,0,0,3'b111,0,0,0,O_DEC,0);
    add(1,1,1,0,3'b111,0,0,0,O_LFD,0);
    add(1,1,0,0,3'b111,0,0,0,O_LD ,0);
    add(1,1,0,0,3'b111,0,0,0,O_LD ,0);
    add(1,0,0,0,3'b111,0,0,0,O_LP ,0);
    add(1,0,0,0,3'b111,0,0,0,O_CPE,0);
    add(1,0,0,0,3'b111,0,0,0,O_DEC,0);
    add(1,1,0,0,3'b111,0,0,0,O_LFD,0);
    add(1,1,0,0,3'b111,0,0,0,O_LD ,0);
    add(1,1,0,1,3'b111,0,0,0,O_FUL,0);
    add(1,1,0,1,3'b111,0,0,0,O_FUL,1);
    add(1,1,0,1,3'b111,0,0,0,O_FUL,2);
    add(1,1,0,0,3'b111,0,0,0,O_LAF,3);
    add(1,0,0,0,3'b111,0,0,1,O_LP ,3);
    add(1,0,0,0,3'b111,0,0,0,O_CPE,3);
    add(1,0,0,1,3'b111,0,0,0,O_FUL,3);
    add(1,0,0,0,3'b111,0,0,0,O_LAF,4);
    add(1,0,0,0,3'b111,0,1,0,O_DEC,4);
    add(1,1,2,0,3'b011,0,0,0,O_WTE,4);
    add(1,0,0,0,3'b011,0,0,0,O_WTE,5);
    add(1,0,0,0,3'b011,0,0,0,O_WTE,6);
    add(1,0,0,0,3'b011,0,0,0,O_WTE,7);
    add(1,0,0,0,3'b011,0,0,0,O_WTE,8);
    add(1,0,0,0,3'b111,0,0,0,O_LFD,9);
    add(1,1,0,0,3'b111,0,0,0,O_LD ,9);
    add(0,1,1,1,3'b000,3'b111,1,1,O_DEC,0);
    add(1,1,2,0,3'b011,0,0,0,O_WTE,0);
    add(1,0,0,0,3'b011,3'b001,0,0,O_WTE,1);
    add(1,0,0,0,3'b011,3'b100,0,0,O_DEC,2);
    add(1,1,3,0,3'b111,0,0,0,O_DEC,2);
    add(1,1,3,0,3'b111,0,0,0,O_DEC,2);
    add(1,0,1,0,3'b111,0,0,0,O_DEC,2);
    add(1,1,0,0,3'b111,0,0,0,O_LFD,2);
    add(1,1,0,0,3'b111,3'b001,0,0,O_DEC,2);
    add(1,1,1,0,3'b111,3'b001,0,0,O_LFD,2);
    add(1,1,0,0,3'b111,3'b001,0,0,O_LD ,2);
    add(1,1,0,1,3'b111,3'b010,0,0,O_DEC,2);

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rstn, tbl[i].pv, tbl[i].din, tbl[i].full,
            tbl[i].emp, tbl[i].sr, tbl[i].pd, tbl[i].lpv);
      @(posedge clk); #1;
      chk("vec_outs", i, 32'(outs()), 32'(tbl[i].exp));
`ifdef ROUTER_PKT_CTRL_STALL_CNT_EN
      chk("vec_cnt", i, 32'(stall_cnt), 32'(tbl[i].cnt));
`endif
    end

    // Random run against the model, starting from reset
    m_ph = M_DEC; m_addr = 0; m_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rs, pv, fl, pd, lp;
      logic [1:0] dn;
      logic [2:0] em, sr;
      rs = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      pv = ($urandom_range(0, 3) != 0);
      dn = 2'($urandom_range(0, 3));
      fl = ($urandom_range(0, 3) == 0);
      em = 3'($urandom);
      sr[0] = ($urandom_range(0, 19) == 0);
      sr[1] = ($urandom_range(0, 19) == 0);
      sr[2] = ($urandom_range(0, 19) == 0);
      pd = ($urandom_range(0, 3) == 0);
      lp = ($urandom_range(0, 2) == 0);
      drive(rs, pv, dn, fl, em, sr, pd, lp);
      m_step(rs, pv, dn, fl, em, sr, pd, lp);
      @(posedge clk); #1;
      chk("rnd_outs", i, 32'(outs()), 32'(m_outs(m_ph)));
`ifdef ROUTER_PKT_CTRL_STALL_CNT_EN
      chk("rnd_cnt", i, 32'(stall_cnt), 32'(m_cnt));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
